// File: rtl/uart_pkg.sv
// Shared types and constants for the UART snapshot frame packer.
// Used by uart_frame_packer and its reference models.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  // XOR of the lowest n bytes of vec (n <= 16).
  function automatic logic [7:0] xor_reduce_bytes(input logic [127:0] vec,
                                                  input int unsigned  n);
    logic [7:0] acc;
    acc = 8'h00;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < n) acc = acc ^ vec[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// registered rising-edge pulse (one clock wide).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q, rise_q;
  logic s1_d, s2_d, s3_d, rise_d;

  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/uart_frame_packer.sv
// Captures the debug snapshot on each slow-clock rising edge and streams it as
// header / payload / XOR checksum bytes. Define FRAME_SEQ_EN for a sequence byte.
//
// state | meaning
// IDLE  | waiting for an enabled trigger edge
// HDR   | presenting HEADER_BYTE
// SEQ   | presenting the frame sequence number (FRAME_SEQ_EN only)
// PAY   | presenting shadow byte idx, MSB byte first
// CSUM  | presenting XOR of all payload (and sequence) bytes
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 12,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEF,
  parameter int         DROP_W        = 8
) (
  input  logic                       CLK100MHZ,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       trig,
  input  logic [PAYLOAD_BYTES*8-1:0] snap_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [DROP_W-1:0]          dropped
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

  state_e                     state_q, state_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 csum_q, csum_d;
  logic [PAYLOAD_BYTES*8-1:0] shadow_q, shadow_d;
  logic [DROP_W-1:0]          dropped_q, dropped_d;
`ifdef FRAME_SEQ_EN
  logic [7:0]                 seq_q, seq_d;
`endif

  logic             trig_rise;
  logic             xfer;
  logic [IDX_W-1:0] idx_dec;

  sync_edge u_sync_edge (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .async_in (trig),
    .rise     (trig_rise)
  );

  assign xfer    = tx_valid_q & tx_ready;
  assign idx_dec = idx_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    shadow_d   = shadow_q;
    dropped_d  = dropped_q;
`ifdef FRAME_SEQ_EN
    seq_d      = seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (trig_rise && en) begin
          state_d    = HDR;
          shadow_d   = snap_data;
          csum_d     = 8'h00;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER_BYTE;
        end
      end
      HDR: begin
        if (xfer) begin
`ifdef FRAME_SEQ_EN
          state_d   = SEQ;
          tx_data_d = seq_q;
`else
          state_d   = PAY;
          idx_d     = IDX_LAST;
          tx_data_d = shadow_q[{IDX_LAST, 3'b000} +: 8];
`endif
        end
      end
`ifdef FRAME_SEQ_EN
      SEQ: begin
        if (xfer) begin
          state_d   = PAY;
          csum_d    = csum_q ^ tx_data_q;
          idx_d     = IDX_LAST;
          tx_data_d = shadow_q[{IDX_LAST, 3'b000} +: 8];
        end
      end
`endif
      PAY: begin
        if (xfer) begin
          csum_d = csum_q ^ tx_data_q;
          if (idx_q == '0) begin
            state_d   = CSUM;
            tx_data_d = csum_q ^ tx_data_q;
          end else begin
            idx_d     = idx_dec;
            tx_data_d = shadow_q[{idx_dec, 3'b000} +: 8];
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
`ifdef FRAME_SEQ_EN
          seq_d      = seq_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase

    // Any enabled edge outside IDLE is lost, including one coinciding with the CSUM transfer.
    if (trig_rise && en && (state_q != IDLE) && (dropped_q != '1)) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      shadow_q   <= '0;
      dropped_q  <= '0;
`ifdef FRAME_SEQ_EN
      seq_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      shadow_q   <= shadow_d;
      dropped_q  <= dropped_d;
`ifdef FRAME_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);
  assign dropped  = dropped_q;

endmodule
